// File: rtl/conv_tap_mac_if.sv
// Request/result bundle between the window buffer, the tap MAC and the edge-magnitude stage.
// The master drives the window and coefficients; the slave (conv_tap_mac) returns the signed sum.
interface conv_tap_mac_if #(
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned COEF_W = 5,
    parameter int unsigned ACC_W  = 13
);
    logic                             start;
    logic [1:0]                       mode;
    logic [2:0][2:0][PIX_W-1:0]       pixels;
    logic [2:0][2:0][COEF_W-1:0]      filter;
    logic                             busy;
    logic                             done;
    logic [ACC_W-1:0]                 result;

    modport master (
        output start, mode, pixels, filter,
        input  busy, done, result
    );

    modport slave (
        input  start, mode, pixels, filter,
        output busy, done, result
    );
endinterface

// File: rtl/conv_tap_mac.sv
// 3x3 convolution tap sequencer with a registered signed MAC; X/Y use 6 taps, FULL uses 9.
// Pixel (i,j) is weighted by filter[j][2-i]; the result is valid in the cycle done is high.
module conv_tap_mac #(
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned COEF_W = 5,
    parameter int unsigned ACC_W  = 13
) (
    input  logic          clk,
    input  logic          n_rst,
    conv_tap_mac_if.slave bus
);
    localparam int unsigned PROD_W = PIX_W + COEF_W + 1;

    if (ACC_W < PIX_W + COEF_W + 4) begin : g_bad_acc_w
        $error("conv_tap_mac: ACC_W must be at least PIX_W+COEF_W+4");
    end

    typedef enum logic [1:0] {IDLE, TAP, DRAIN, DONE} state_e;

    state_e                         state_q, state_d;
    logic [3:0]                     k_q, k_d;
    logic [1:0]                     mode_q, mode_d;
    logic [2:0][2:0][PIX_W-1:0]     pix_q, pix_d;
    logic [2:0][2:0][COEF_W-1:0]    flt_q, flt_d;
    logic signed [PROD_W-1:0]       prod_q, prod_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [ACC_W-1:0]        result_q, result_d;

    logic [1:0]                     div3, mod3, ti, tj;
    logic [3:0]                     k_last;
    logic [PIX_W-1:0]               tap_pix;
    logic [COEF_W-1:0]              tap_coef;
    logic signed [PROD_W-1:0]       tap_prod;
    logic signed [ACC_W-1:0]        prod_ext;

    // Modes 10 and 11 both run the full 9-tap raster.
    assign k_last = mode_q[1] ? 4'd8 : 4'd5;

    always_comb begin
        div3 = 2'd0;
        mod3 = 2'd0;
        case (k_q)
            4'd0:    begin div3 = 2'd0; mod3 = 2'd0; end
            4'd1:    begin div3 = 2'd0; mod3 = 2'd1; end
            4'd2:    begin div3 = 2'd0; mod3 = 2'd2; end
            4'd3:    begin div3 = 2'd1; mod3 = 2'd0; end
            4'd4:    begin div3 = 2'd1; mod3 = 2'd1; end
            4'd5:    begin div3 = 2'd1; mod3 = 2'd2; end
            4'd6:    begin div3 = 2'd2; mod3 = 2'd0; end
            4'd7:    begin div3 = 2'd2; mod3 = 2'd1; end
            4'd8:    begin div3 = 2'd2; mod3 = 2'd2; end
            default: begin div3 = 2'd0; mod3 = 2'd0; end
        endcase
    end

    // X walks rows 0 then 2, Y walks columns 0 then 2; div3 picks the outer row/column.
    always_comb begin
        ti = 2'd0;
        tj = 2'd0;
        case (mode_q)
            2'b00: begin
                ti = (div3 == 2'd0) ? 2'd0 : 2'd2;
                tj = mod3;
            end
            2'b01: begin
                ti = mod3;
                tj = (div3 == 2'd0) ? 2'd0 : 2'd2;
            end
            default: begin
                ti = div3;
                tj = mod3;
            end
        endcase
    end

    assign tap_pix  = pix_q[ti][tj];
    assign tap_coef = flt_q[tj][2'd2 - ti];
    assign tap_prod = $signed({1'b0, tap_pix}) * $signed(tap_coef);
    assign prod_ext = ACC_W'(prod_q);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        mode_d   = mode_q;
        pix_d    = pix_q;
        flt_d    = flt_q;
        prod_d   = '0;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = TAP;
                    k_d     = '0;
                    mode_d  = bus.mode;
                    pix_d   = bus.pixels;
                    flt_d   = bus.filter;
                    acc_d   = '0;
                end
            end
            TAP: begin
                prod_d = tap_prod;
                // prod_q is still zero on the first tap, so accumulating unconditionally is safe.
                acc_d  = acc_q + prod_ext;
                if (k_q == k_last) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            DRAIN: begin
                acc_d    = acc_q + prod_ext;
                result_d = acc_q + prod_ext;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            mode_q   <= '0;
            pix_q    <= '0;
            flt_q    <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            pix_q    <= pix_d;
            flt_q    <= flt_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_conv_tap_mac.sv
// Bench for conv_tap_mac: directed table, random transactions against a tap-set model,
// continuous-start handshake and asynchronous reset in the middle of a calculation.
module tb_conv_tap_mac;
    localparam int PIX_W  = 4;
    localparam int COEF_W = 5;
    localparam int ACC_W  = 13;

    typedef logic [2:0][2:0][PIX_W-1:0]  pix_t;
    typedef logic [2:0][2:0][COEF_W-1:0] flt_t;

    typedef struct {
        string      nm;
        logic [1:0] md;
        pix_t       p;
        flt_t       f;
        int         exp_v;
        int         exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    conv_tap_mac_if #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) bus ();

    conv_tap_mac #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int last_result = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Sum over the taps a mode uses: X skips row 1, Y skips column 1, FULL uses all nine.
    task automatic ref_model(input logic [1:0] md, input pix_t p, input flt_t f,
                             output int s, output int n);
        int c;
        bit use_tap;
        s = 0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                case (md)
                    2'b00:   use_tap = (i != 1);
                    2'b01:   use_tap = (j != 1);
                    default: use_tap = 1'b1;
                endcase
                if (use_tap) begin
                    c = $signed(f[j][2-i]);
                    s += int'(p[i][j]) * c;
                    n++;
                end
            end
        end
    endtask

    task automatic rand_inputs(output logic [1:0] md, output pix_t p, output flt_t f);
        md = 2'($urandom_range(3, 0));
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p[i][j] = PIX_W'($urandom_range(15, 0));
                f[i][j] = COEF_W'($urandom_range(31, 0));
            end
        end
    endtask

    // Starts a calculation, scrambles the inputs after acceptance, and checks busy/done/result
    // on every cycle until two cycles past the expected done pulse.
    task automatic run_calc(input string nm, input logic [1:0] md, input pix_t p, input flt_t f,
                            input int exp_v, input int exp_lat);
        logic [1:0] jm;
        pix_t       jp;
        flt_t       jf;
        @(negedge clk);
        bus.mode   = md;
        bus.pixels = p;
        bus.filter = f;
        bus.start  = 1'b1;
        for (int c = 1; c <= exp_lat + 2; c++) begin
            @(negedge clk);
            check({nm, " busy"}, int'(bus.busy), (c <= exp_lat) ? 1 : 0);
            check({nm, " done"}, int'(bus.done), (c == exp_lat) ? 1 : 0);
            if (c == exp_lat)
                check({nm, " result"}, $signed(bus.result), exp_v);
            if (c == 1) begin
                bus.start = 1'b0;
                rand_inputs(jm, jp, jf);
                bus.mode   = jm;
                bus.pixels = jp;
                bus.filter = jf;
            end
        end
        last_result = exp_v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[5];
        pix_t       p;
        flt_t       f;
        flt_t       fx;
        logic [1:0] md;
        int         s;
        int         n;
        int         period;
        int         exp_done;
        int         exp_busy;
        int         exp_hold;
        logic [4:0] neg_col[3];
        logic [4:0] pos_col[3];

        neg_col = '{5'h1F, 5'h1E, 5'h1F};
        pos_col = '{5'h01, 5'h02, 5'h01};
        fx = '0;
        for (int j = 0; j < 3; j++) begin
            fx[j][2] = neg_col[j];
            fx[j][0] = pos_col[j];
        end

        p = '0;
        for (int j = 0; j < 3; j++) begin
            p[1][j] = 4'd7;
            p[2][j] = 4'd15;
        end
        vecs[0] = '{"x_edge", 2'b00, p, fx, 60, 8};

        p = '0;
        for (int j = 0; j < 3; j++) begin
            p[0][j] = 4'd15;
            p[1][j] = 4'd7;
        end
        vecs[1] = '{"x_inv", 2'b00, p, fx, -60, 8};

        for (int i = 0; i < 3; i++) begin
            p[i][0] = 4'd3;
            p[i][1] = 4'd15;
            p[i][2] = 4'd5;
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                f[i][j] = 5'h01;
        vecs[2] = '{"y_mode", 2'b01, p, f, 24, 8};

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                p[i][j] = 4'd15;
                f[i][j] = 5'h10;
            end
        vecs[3] = '{"full_ext", 2'b10, p, f, -2160, 11};
        vecs[4] = '{"full_m11", 2'b11, p, f, -2160, 11};

        n_rst      = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = '0;
        bus.pixels = '0;
        bus.filter = '0;
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset result", $signed(bus.result), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle busy", int'(bus.busy), 0);

        for (int t = 0; t < 5; t++)
            run_calc(vecs[t].nm, vecs[t].md, vecs[t].p, vecs[t].f, vecs[t].exp_v, vecs[t].exp_lat);

        for (int r = 0; r < 25; r++) begin
            rand_inputs(md, p, f);
            ref_model(md, p, f, s, n);
            run_calc("rand", md, p, f, s, n + 2);
        end

        // Start held high: one acceptance per IDLE cycle, inputs zeroed right after the first.
        ref_model(2'b00, vecs[0].p, vecs[0].f, s, n);
        period   = n + 3;
        exp_hold = last_result;
        @(negedge clk);
        bus.mode   = 2'b00;
        bus.pixels = vecs[0].p;
        bus.filter = vecs[0].f;
        bus.start  = 1'b1;
        for (int c = 1; c <= 3 * period - 1; c++) begin
            @(negedge clk);
            exp_done = ((c + 1) % period == 0) ? 1 : 0;
            exp_busy = (c % period != 0) ? 1 : 0;
            if (exp_done == 1)
                exp_hold = (c == period - 1) ? s : 0;
            check("hs busy", int'(bus.busy), exp_busy);
            check("hs done", int'(bus.done), exp_done);
            check("hs result", $signed(bus.result), exp_hold);
            if (c == 1)
                bus.pixels = '0;
        end
        bus.start   = 1'b0;
        last_result = 0;

        run_calc("pre_rst", vecs[0].md, vecs[0].p, vecs[0].f, vecs[0].exp_v, vecs[0].exp_lat);

        rand_inputs(md, p, f);
        @(negedge clk);
        bus.mode   = 2'b10;
        bus.pixels = p;
        bus.filter = f;
        bus.start  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1)
                bus.start = 1'b0;
        end
        check("midop busy", int'(bus.busy), 1);
        check("midop result", $signed(bus.result), last_result);
        #2;
        n_rst = 1'b0;
        #1;
        check("async rst busy", int'(bus.busy), 0);
        check("async rst done", int'(bus.done), 0);
        check("async rst result", $signed(bus.result), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("post rst busy", int'(bus.busy), 0);
        check("post rst result", $signed(bus.result), 0);

        rand_inputs(md, p, f);
        md = 2'b10;
        ref_model(md, p, f, s, n);
        run_calc("after_rst", md, p, f, s, n + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
